// File: rtl/hash_core_scheduler.sv
// Round-robin scheduler that time-shares one iterative hash round core among
// NREQ requesters, sequencing each job through LOAD, ROUNDS x RUN and CAPTURE.
module hash_core_scheduler #(
  parameter int NREQ   = 4,
  parameter int ROUNDS = 32,
  parameter int CW     = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            core_load,
  output logic            core_en,
  output logic [CW-1:0]   round_idx,
  output logic            core_capture,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

  state_t          r_state, w_nextState;
  logic [PW-1:0]   r_ptr, w_nextPtr;
  logic [PW-1:0]   r_owner, w_nextOwner;
  logic [NREQ-1:0] r_grant, w_nextGrant;
  logic [CW-1:0]   r_cnt, w_nextCnt;
  logic [PW-1:0]   w_selIdx;
  logic            w_selValid;

  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Scan from the highest offset down so the nearest requester at/after the pointer wins.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrapAdd(r_ptr, i)]) begin
        w_selValid = 1'b1;
        w_selIdx   = wrapAdd(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextCnt   = r_cnt;
    w_nextPtr   = r_ptr;
    w_nextOwner = r_owner;
    case (r_state)
      IDLE: begin
        if (w_selValid) begin
          w_nextGrant = NREQ'(1) << w_selIdx;
          w_nextOwner = w_selIdx;
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_nextCnt   = '0;
        w_nextState = RUN;
      end
      RUN: begin
        if (r_cnt == CW'(ROUNDS - 1)) begin
          w_nextCnt   = '0;
          w_nextState = CAPTURE;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        // Owner moves to lowest priority so everyone else pending is served first.
        w_nextPtr   = wrapAdd(r_owner, 1);
        w_nextGrant = '0;
        w_nextState = IDLE;
      end
      default: begin
        w_nextGrant = '0;
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_owner <= w_nextOwner;
      r_grant <= w_nextGrant;
      r_cnt   <= w_nextCnt;
    end
  end

  assign grant        = r_grant;
  assign core_load    = (r_state == LOAD);
  assign core_en      = (r_state == RUN);
  assign round_idx    = (r_state == RUN) ? r_cnt : '0;
  assign core_capture = (r_state == CAPTURE);
  assign done         = (r_state == CAPTURE) ? r_grant : '0;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_hash_core_scheduler.sv
// Directed bench for hash_core_scheduler: default-parameter instance plus a
// ROUNDS=1 instance, checked against hand-computed cycle tables.
module tb_hash_core_scheduler;

  typedef struct packed {
    logic [3:0] grant;
    logic       load;
    logic       en;
    logic [5:0] idx;
    logic       cap;
    logic [3:0] dn;
    logic       busy;
  } outs_t;

  typedef struct {
    int    scen;
    int    cyc;
    outs_t exp;
  } vec_t;

  localparam int NV = 18;

  logic       clk;
  logic       reset;
  logic [3:0] req, req1;
  logic [3:0] grant, done, grant1, done1;
  logic       core_load, core_en, core_capture, busy;
  logic       core_load1, core_en1, core_capture1, busy1;
  logic [5:0] round_idx;
  logic [0:0] round_idx1;

  int vectors;
  int miscompares;
  vec_t vecs[NV];

  hash_core_scheduler #(.NREQ(4), .ROUNDS(32), .CW(6)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .core_load(core_load), .core_en(core_en), .round_idx(round_idx),
    .core_capture(core_capture), .done(done), .busy(busy)
  );

  hash_core_scheduler #(.NREQ(4), .ROUNDS(1), .CW(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .grant(grant1),
    .core_load(core_load1), .core_en(core_en1), .round_idx(round_idx1),
    .core_capture(core_capture1), .done(done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic [3:0] g, input logic l, input logic e,
                               input int idx, input logic cp, input logic [3:0] d,
                               input logic b);
    outs_t o;
    o.grant = g; o.load = l; o.en = e; o.idx = 6'(idx);
    o.cap = cp; o.dn = d; o.busy = b;
    return o;
  endfunction

  function automatic vec_t mkVec(input int s, input int c, input outs_t e);
    vec_t v;
    v.scen = s; v.cyc = c; v.exp = e;
    return v;
  endfunction

  function automatic outs_t curOut(input int which);
    outs_t o;
    if (which == 0) begin
      o.grant = grant; o.load = core_load; o.en = core_en; o.idx = round_idx;
      o.cap = core_capture; o.dn = done; o.busy = busy;
    end else begin
      o.grant = grant1; o.load = core_load1; o.en = core_en1; o.idx = {5'b0, round_idx1};
      o.cap = core_capture1; o.dn = done1; o.busy = busy1;
    end
    return o;
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] r1);
    req  = r;
    req1 = r1;
  endtask

  task automatic checkOutput(input int which, input string name, input outs_t exp);
    outs_t act;
    act = curOut(which);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got grant=%b load=%b en=%b idx=%0d cap=%b done=%b busy=%b, expected grant=%b load=%b en=%b idx=%0d cap=%b done=%b busy=%b",
               name, act.grant, act.load, act.en, act.idx, act.cap, act.dn, act.busy,
               exp.grant, exp.load, exp.en, exp.idx, exp.cap, exp.dn, exp.busy);
    end
  endtask

  task automatic checkInvariant(input string name);
    logic ok;
    ok = $onehot0(grant)
         && ($countones({core_load, core_en, core_capture}) == (busy ? 1 : 0))
         && ((done & ~grant) == 4'b0);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL invariant %s: got grant=%b load=%b en=%b cap=%b done=%b busy=%b, required one-hot grant, one phase when busy, done within grant",
               name, grant, core_load, core_en, core_capture, done, busy);
    end
  endtask

  // Leaves the bench on a negedge with reset just released; that cycle is cycle 0.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b0, 4'b0);
    @(negedge clk);
    checkOutput(0, "reset state", '0);
    checkOutput(1, "reset state r1", '0);
    reset = 1'b0;
  endtask

  task automatic runTable(input int scen, input int lastCyc);
    doReset();
    for (int c = 0; c <= lastCyc; c++) begin
      if (scen == 0) applyStimulus((c <= 34) ? 4'b0100 : 4'b0000, 4'b0);
      else           applyStimulus(4'b1111, 4'b0);
      for (int v = 0; v < NV; v++) begin
        if (vecs[v].scen == scen && vecs[v].cyc == c)
          checkOutput(0, $sformatf("table scen%0d cyc%0d", scen, c), vecs[v].exp);
      end
      checkInvariant($sformatf("scen%0d cyc%0d", scen, c));
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(4'b0, 4'b0);

    // Scenario 0: requester 2 alone; scenario 1: all four requesting.
    vecs[0]  = mkVec(0, 0,   mk(4'b0000, 0, 0, 0,  0, 4'b0000, 0));
    vecs[1]  = mkVec(0, 1,   mk(4'b0100, 1, 0, 0,  0, 4'b0000, 1));
    vecs[2]  = mkVec(0, 2,   mk(4'b0100, 0, 1, 0,  0, 4'b0000, 1));
    vecs[3]  = mkVec(0, 17,  mk(4'b0100, 0, 1, 15, 0, 4'b0000, 1));
    vecs[4]  = mkVec(0, 33,  mk(4'b0100, 0, 1, 31, 0, 4'b0000, 1));
    vecs[5]  = mkVec(0, 34,  mk(4'b0100, 0, 0, 0,  1, 4'b0100, 1));
    vecs[6]  = mkVec(0, 35,  mk(4'b0000, 0, 0, 0,  0, 4'b0000, 0));
    vecs[7]  = mkVec(0, 36,  mk(4'b0000, 0, 0, 0,  0, 4'b0000, 0));
    vecs[8]  = mkVec(1, 1,   mk(4'b0001, 1, 0, 0,  0, 4'b0000, 1));
    vecs[9]  = mkVec(1, 34,  mk(4'b0001, 0, 0, 0,  1, 4'b0001, 1));
    vecs[10] = mkVec(1, 35,  mk(4'b0000, 0, 0, 0,  0, 4'b0000, 0));
    vecs[11] = mkVec(1, 36,  mk(4'b0010, 1, 0, 0,  0, 4'b0000, 1));
    vecs[12] = mkVec(1, 69,  mk(4'b0010, 0, 0, 0,  1, 4'b0010, 1));
    vecs[13] = mkVec(1, 71,  mk(4'b0100, 1, 0, 0,  0, 4'b0000, 1));
    vecs[14] = mkVec(1, 104, mk(4'b0100, 0, 0, 0,  1, 4'b0100, 1));
    vecs[15] = mkVec(1, 139, mk(4'b1000, 0, 0, 0,  1, 4'b1000, 1));
    vecs[16] = mkVec(1, 141, mk(4'b0001, 1, 0, 0,  0, 4'b0000, 1));
    vecs[17] = mkVec(1, 174, mk(4'b0001, 0, 0, 0,  1, 4'b0001, 1));

    $display("[TB] table scenarios");
    runTable(0, 36);
    runTable(1, 175);

    $display("[TB] pointer wrap after serving requester 2");
    doReset();
    for (int c = 0; c <= 71; c++) begin
      applyStimulus((c <= 34) ? 4'b0100 : 4'b0101, 4'b0);
      if (c == 36) checkOutput(0, "wrap grant r0", mk(4'b0001, 1, 0, 0, 0, 4'b0000, 1));
      if (c == 69) checkOutput(0, "wrap done r0",  mk(4'b0001, 0, 0, 0, 1, 4'b0001, 1));
      if (c == 71) checkOutput(0, "wrap grant r2", mk(4'b0100, 1, 0, 0, 0, 4'b0000, 1));
      checkInvariant($sformatf("wrap cyc%0d", c));
      @(negedge clk);
    end

    $display("[TB] reset in the middle of a run");
    doReset();
    for (int c = 0; c <= 52; c++) begin
      applyStimulus((c <= 34) ? 4'b0100 : 4'b0010, 4'b0);
      if (c == 52) checkOutput(0, "midrun idx15", mk(4'b0010, 0, 1, 15, 0, 4'b0000, 1));
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput(0, "midrun after reset", '0);
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0);
    @(negedge clk);
    checkOutput(0, "midrun pointer cleared", mk(4'b0001, 1, 0, 0, 0, 4'b0000, 1));

    $display("[TB] owner drops request mid-job");
    doReset();
    for (int c = 0; c <= 35; c++) begin
      applyStimulus((c <= 6) ? 4'b0010 : 4'b0000, 4'b0);
      if (c == 7)  checkOutput(0, "drop run5",    mk(4'b0010, 0, 1, 5, 0, 4'b0000, 1));
      if (c == 34) checkOutput(0, "drop done",    mk(4'b0010, 0, 0, 0, 1, 4'b0010, 1));
      if (c == 35) checkOutput(0, "drop to idle", '0);
      @(negedge clk);
    end

    $display("[TB] single-round instance");
    doReset();
    for (int c = 0; c <= 4; c++) begin
      applyStimulus(4'b0, (c <= 2) ? 4'b0001 : 4'b0000);
      if (c == 1) checkOutput(1, "r1 load",    mk(4'b0001, 1, 0, 0, 0, 4'b0000, 1));
      if (c == 2) checkOutput(1, "r1 round0",  mk(4'b0001, 0, 1, 0, 0, 4'b0000, 1));
      if (c == 3) checkOutput(1, "r1 capture", mk(4'b0001, 0, 0, 0, 1, 4'b0001, 1));
      if (c == 4) checkOutput(1, "r1 idle",    '0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hash_core_scheduler.md
Name: hash_core_scheduler

Overview:
- Shares one iterative hash round core among NREQ requesters (nonce workers) using round-robin arbitration.
- Sequences each granted job through three phases: a load cycle, ROUNDS round-enable cycles with a round index, and a capture cycle.
- Sits between the requester array and the round core. It replaces free-running round counters as the single source of round timing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ROUNDS, 32, round cycles per job (>=1).
- CW, 6, round_idx width; must satisfy 2^CW >= ROUNDS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester job request, level; one bit per requester.
- grant  output  NREQ  one-hot owner of the core, registered. Held from LOAD through CAPTURE.
- core_load  output  1  core loads message/nonce of the granted requester.
- core_en  output  1  core executes one round this cycle.
- round_idx  output  CW  current round number, 0..ROUNDS-1 during RUN, else 0.
- core_capture  output  1  core result valid; requester latches digest.
- done  output  NREQ  one-cycle pulse to the owner, coincident with core_capture.
- busy  output  1  high in LOAD, RUN, CAPTURE.

Behaviour:
- Reset:
  - state=IDLE, priority pointer=0 (requester 0 highest).
  - grant=0, done=0, core_load=0, core_en=0, core_capture=0, round_idx=0, busy=0.
  - Reset wins over every other event.
- States are IDLE, LOAD, RUN and CAPTURE. All outputs are registered, or decoded from registered state only; there is no combinational path from req to any output.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit at or after the pointer, wrapping modulo NREQ.
  - Register the one-hot grant and go to LOAD.
- LOAD (1 cycle): core_load=1, round_idx=0, go to RUN with round counter=0.
- RUN (ROUNDS cycles):
  - core_en=1 and round_idx=counter.
  - The counter increments each cycle.
  - When counter==ROUNDS-1, clear the counter and go to CAPTURE. There is no wrap past ROUNDS-1.
- CAPTURE (1 cycle):
  - core_capture=1 and done=grant.
  - pointer = index(grant)+1 mod NREQ.
  - Go to IDLE; grant clears on the IDLE entry.
- Latency and throughput:
  - req sampled in IDLE at cycle 0 gives LOAD at 1, RUN at 2..ROUNDS+1, and CAPTURE at ROUNDS+2.
  - The mandatory IDLE cycle follows at ROUNDS+3.
  - A job occupies ROUNDS+3 cycles (35 at default).
- Request rules:
  - A requester holds req until its done pulse.
  - If the owner drops req mid-job, the job still completes and done still pulses; no abort.
  - A req rising during a job for a non-owner waits; it is evaluated only in IDLE.
  - If the owner holds req through CAPTURE, it is re-served only after all other pending requesters, because the pointer has advanced.
- Fairness: with all req high, grants rotate strictly 0,1,...,NREQ-1,0,...
- Reset mid-job: the next cycle is IDLE with all outputs 0. No done pulse is issued and the pointer returns to 0.
- Invariants:
  - grant is zero or one-hot.
  - Exactly one of core_load, core_en, core_capture is high when busy=1.
  - done is a subset of grant.

Test Plan:
- Single requester: assert req=4'b0100 at cycle 0.
  - grant=0100 from cycle 1; core_load at 1; core_en at 2..33 with round_idx 0..31.
  - core_capture and done=0100 at 34; busy low at 35.
- All requesters: hold req=4'b1111 continuously.
  - done pulses to 0,1,2,3,0 at cycles 34, 69, 104, 139, 174.
  - No grant is ever non-one-hot.
- Pointer fairness: serve requester 2, then assert req=4'b0101 in the IDLE cycle → requester 0 is granted next (wraps past 3).
- Reset mid-run: pulse reset at round_idx=15.
  - Next cycle all outputs are 0, with no done pulse.
  - Then req=1111 → requester 0 is granted first.
- Owner drops req: drop req[1] at RUN cycle 5 of its job → job completes and done[1] still pulses at CAPTURE.
- Edge parameter: ROUNDS=1, CW=1, req=0001 → LOAD at 1, single core_en at 2 with round_idx=0, CAPTURE at 3.
